// File: rtl/aes_dec_scheduler_if.sv
// Handshake bundle between the two decrypt requesters, the scheduler and the decrypt core.
// The scheduler sits on the slave modport; requesters and the core model sit on master.
interface aes_dec_scheduler_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_ct;
  logic [127:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_ct;
  logic [127:0] req1_key;
  logic         resp0_valid;
  logic         resp0_ready;
  logic [127:0] resp0_pt;
  logic         resp0_err;
  logic         resp1_valid;
  logic         resp1_ready;
  logic [127:0] resp1_pt;
  logic         resp1_err;
  logic         core_D_int;
  logic [127:0] core_ct;
  logic [127:0] core_key;
  logic [127:0] core_pt;
  logic         core_D_done;

  modport slave (
    input  req0_valid, req0_ct, req0_key,
    input  req1_valid, req1_ct, req1_key,
    input  resp0_ready, resp1_ready,
    input  core_pt, core_D_done,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_pt, resp0_err,
    output resp1_valid, resp1_pt, resp1_err,
    output core_D_int, core_ct, core_key
  );

  modport master (
    output req0_valid, req0_ct, req0_key,
    output req1_valid, req1_ct, req1_key,
    output resp0_ready, resp1_ready,
    output core_pt, core_D_done,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_pt, resp0_err,
    input  resp1_valid, resp1_pt, resp1_err,
    input  core_D_int, core_ct, core_key
  );
endinterface

// File: rtl/aes_dec_scheduler.sv
// Two-requester scheduler for a single AES decrypt core: round-robin grant, start-level
// handshake with timeout, held response per requester and an enforced idle gap between jobs.
//
// state | meaning
// IDLE  | waiting for a request; grant offered combinationally
// ISSUE | core_D_int high, waiting for core_D_done or timeout
// RESP  | result held for the granted requester until consumed
// GAP   | core kept idle for GAP_CYCLES before the next job
module aes_dec_scheduler #(
  parameter int TIMEOUT    = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_dec_scheduler_if.slave   bus,
  output logic                 busy,
  output logic [15:0]          jobs_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  state_t          state_q, state_d;
  logic            grant_c, accept_c, timeout_c, resp_hs_c, gap_end_c;
  logic            grant_id_q, last_grant_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q;
  logic [127:0]    ct_q, key_q, pt_q;
  logic            err_q, d_int_q;
  logic [15:0]     jobs_q;

  // Tie goes to the requester not served last; last_grant resets to 1 so req0 wins first.
  always_comb begin
    grant_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_c = ~last_grant_q;
    else if (bus.req1_valid)              grant_c = 1'b1;
  end

  assign accept_c  = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
  assign timeout_c = (state_q == ISSUE) && !bus.core_D_done && (cnt_q == CW'(TIMEOUT - 1));
  assign resp_hs_c = (state_q == RESP) && (grant_id_q ? bus.resp1_ready : bus.resp0_ready);
  assign gap_end_c = (state_q == GAP) && (gap_q == GW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req0_ready = accept_c && !grant_c;
        bus.req1_ready = accept_c && grant_c;
        if (accept_c) state_d = ISSUE;
      end
      ISSUE: if (bus.core_D_done || timeout_c) state_d = RESP;
      RESP: begin
        bus.resp0_valid = !grant_id_q;
        bus.resp1_valid = grant_id_q;
        if (resp_hs_c) state_d = GAP;
      end
      GAP: if (gap_end_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done is only looked at in ISSUE, so a stray pulse elsewhere changes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      gap_q        <= '0;
      ct_q         <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      err_q        <= 1'b0;
      d_int_q      <= 1'b0;
      jobs_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            ct_q         <= grant_c ? bus.req1_ct  : bus.req0_ct;
            key_q        <= grant_c ? bus.req1_key : bus.req0_key;
            grant_id_q   <= grant_c;
            last_grant_q <= grant_c;
            cnt_q        <= '0;
            d_int_q      <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.core_D_done) begin
            pt_q    <= bus.core_pt;
            err_q   <= 1'b0;
            d_int_q <= 1'b0;
            jobs_q  <= jobs_q + 16'd1;
          end else if (timeout_c) begin
            pt_q    <= '0;
            err_q   <= 1'b1;
            d_int_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: if (resp_hs_c) gap_q <= '0;
        GAP:  gap_q <= gap_q + GW'(1);
        default: ;
      endcase
    end
  end

  assign bus.core_D_int = d_int_q;
  assign bus.core_ct    = ct_q;
  assign bus.core_key   = key_q;
  assign bus.resp0_pt   = pt_q;
  assign bus.resp1_pt   = pt_q;
  assign bus.resp0_err  = err_q;
  assign bus.resp1_err  = err_q;
  assign busy           = (state_q != IDLE);
  assign jobs_done      = jobs_q;

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Directed bench for aes_dec_scheduler: a small decrypt-core model answers core_D_int after a
// programmable delay; all expected values below are worked out by hand from the block behaviour.
module tb_aes_dec_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] jobs_done;

  aes_dec_scheduler_if bus ();

  aes_dec_scheduler #(.TIMEOUT(32), .GAP_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;

  // core model
  bit           core_en  = 1'b1;
  int           core_lat = 3;
  logic [127:0] core_pt_val = '0;
  bit           model_done = 1'b0;
  bit           stale_req  = 1'b0;
  bit           sent = 1'b0;
  int           mcnt = 0;

  assign bus.core_D_done = model_done | stale_req;
  assign bus.core_pt     = model_done ? core_pt_val : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  always @(negedge clk) begin
    if (rst || !bus.core_D_int) begin
      mcnt = 0; sent = 1'b0; model_done = 1'b0;
    end else if (!sent && core_en) begin
      mcnt++;
      if (mcnt == core_lat) begin model_done = 1'b1; sent = 1'b1; end
    end else begin
      model_done = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts cycles from the current (accept) cycle until respN_valid is seen, bounded.
  task automatic wait_resp(input bit n, input int maxc, output int cyc);
    cyc = 0;
    while (cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (n ? bus.resp1_valid : bus.resp0_valid) break;
    end
  endtask

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_B  = 128'h6bc1bee22e409f96e93d7e117393172a;

  initial begin
    int cyc;
    int nresp;
    int low_run;
    bit seen_high;
    logic prev;

    bus.req0_valid = 0; bus.req0_ct = CT_A; bus.req0_key = KEY_A;
    bus.req1_valid = 0; bus.req1_ct = CT_B; bus.req1_key = KEY_B;
    bus.resp0_ready = 0; bus.resp1_ready = 0;

    // reset values, with a request pending during reset
    tick(2);
    bus.req0_valid = 1;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_resp0_valid", bus.resp0_valid, 0);
    chk("rst_dint", bus.core_D_int, 0);
    chk("rst_core_ct", bus.core_ct, 0);
    chk("rst_pt", bus.resp0_pt, 0);

    // single job on req0
    rst = 0;
    #1;
    chk("a_req0_ready", bus.req0_ready, 1);
    chk("a_req1_ready", bus.req1_ready, 0);
    core_pt_val = PT_A; core_lat = 3;
    wait_resp(0, 50, cyc);
    chk("a_latency", cyc, 4);
    chk("a_core_ct", bus.core_ct, CT_A);
    chk("a_core_key", bus.core_key, KEY_A);
    chk("a_pt", bus.resp0_pt, PT_A);
    chk("a_err", bus.resp0_err, 0);
    chk("a_jobs", jobs_done, 1);
    chk("a_resp1_valid", bus.resp1_valid, 0);
    chk("a_dint_low", bus.core_D_int, 0);
    bus.req0_valid = 0;
    bus.req1_valid = 1;
    bus.resp0_ready = 1;
    tick(1);
    bus.resp0_ready = 0;
    chk("a_resp0_dropped", bus.resp0_valid, 0);
    chk("a_gap_busy", busy, 1);
    chk("a_gap_no_ready1", bus.req1_ready, 0);
    tick(1);
    chk("a_gap2_no_ready1", bus.req1_ready, 0);
    tick(1);
    chk("b_req1_ready", bus.req1_ready, 1);

    // req1 job, then hold its response under backpressure
    core_pt_val = PT_B;
    wait_resp(1, 50, cyc);
    chk("b_latency", cyc, 4);
    bus.req1_valid = 0;
    bus.req0_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", bus.resp1_valid, 1);
      chk("bp_pt", bus.resp1_pt, PT_B);
      chk("bp_err", bus.resp1_err, 0);
      chk("bp_req0_ready", bus.req0_ready, 0);
      chk("bp_dint", bus.core_D_int, 0);
      tick(1);
    end
    chk("b_jobs", jobs_done, 2);
    bus.resp1_ready = 1;
    tick(1);
    bus.resp1_ready = 0;
    chk("b_resp1_dropped", bus.resp1_valid, 0);
    tick(2);

    // timeout: core never answers
    chk("c_req0_ready", bus.req0_ready, 1);
    core_en = 0;
    wait_resp(0, 60, cyc);
    bus.req0_valid = 0;
    chk("c_timeout_cycles", cyc, 33);
    chk("c_err", bus.resp0_err, 1);
    chk("c_pt", bus.resp0_pt, 0);
    chk("c_dint", bus.core_D_int, 0);
    chk("c_jobs", jobs_done, 2);
    bus.resp0_ready = 1;
    tick(1);
    bus.resp0_ready = 0;
    tick(2);
    core_en = 1;

    // reset in the middle of ISSUE
    core_lat = 20;
    bus.req1_valid = 1;
    #1;
    chk("d_req1_ready", bus.req1_ready, 1);
    tick(5);
    chk("d_in_issue", bus.core_D_int, 1);
    rst = 1;
    tick(1);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_dint", bus.core_D_int, 0);
    chk("d_rst_jobs", jobs_done, 0);
    chk("d_rst_ct", bus.core_ct, 0);
    chk("d_rst_req1_ready", bus.req1_ready, 0);
    chk("d_rst_resp1_valid", bus.resp1_valid, 0);
    bus.req1_valid = 0;
    rst = 0;
    tick(1);
    stale_req = 1;
    tick(1);
    stale_req = 0;
    tick(1);
    chk("d_stale_busy", busy, 0);
    chk("d_stale_jobs", jobs_done, 0);
    chk("d_stale_resp", bus.resp1_valid, 0);
    chk("d_stale_pt", bus.resp1_pt, 0);

    // tie from reset: req0 first, then req1 while both stay valid
    core_lat = 3; core_pt_val = PT_A;
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("e_tie_ready0", bus.req0_ready, 1);
    chk("e_tie_ready1", bus.req1_ready, 0);
    wait_resp(0, 50, cyc);
    chk("e_lat0", cyc, 4);
    chk("e_pt0", bus.resp0_pt, PT_A);
    chk("e_jobs0", jobs_done, 1);
    chk("e_resp_ready_blocked", bus.req1_ready, 0);
    bus.resp0_ready = 1;
    tick(1);
    bus.resp0_ready = 0;
    tick(2);
    chk("e_tie2_ready1", bus.req1_ready, 1);
    chk("e_tie2_ready0", bus.req0_ready, 0);
    core_pt_val = PT_B;
    wait_resp(1, 50, cyc);
    chk("e_lat1", cyc, 4);
    chk("e_pt1", bus.resp1_pt, PT_B);
    chk("e_jobs1", jobs_done, 2);
    bus.resp1_ready = 1;
    tick(1);
    bus.resp1_ready = 0;
    tick(2);
    chk("e_tie3_ready0", bus.req0_ready, 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick(1);
    chk("e_idle", busy, 0);

    // back-to-back on req0 with jobs_done preloaded near wrap
    force dut.jobs_q = 16'hffff;
    tick(1);
    release dut.jobs_q;
    tick(1);
    chk("f_preload", jobs_done, 16'hffff);
    core_pt_val = PT_A;
    bus.req0_valid = 1; bus.resp0_ready = 1;
    nresp = 0; low_run = 0; seen_high = 0; prev = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.core_D_int && !prev && seen_high) chk("f_low_gap", low_run, 4);
      if (bus.core_D_int) begin seen_high = 1; low_run = 0; end
      else low_run++;
      prev = bus.core_D_int;
      if (bus.resp0_valid) begin
        nresp++;
        chk("f_pt", bus.resp0_pt, PT_A);
        if (nresp == 1) chk("f_wrap", jobs_done, 16'h0000);
        if (nresp == 2) begin
          chk("f_after_wrap", jobs_done, 16'h0001);
          bus.req0_valid = 0;
          break;
        end
      end
    end
    chk("f_two_jobs", nresp, 2);
    tick(1);
    bus.resp0_ready = 0;
    tick(3);
    chk("f_end_idle", busy, 0);
    chk("f_end_dint", bus.core_D_int, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
